// File: rtl/wavelet_accelerator_pkg.sv
// Shared types and widths for the wavelet accelerator datapath.
// Imported by the packer/unpacker blocks.
package wavelet_accelerator_pkg;

    localparam int WA_WORD_WIDTH   = 32;
    localparam int WA_PACKET_WIDTH = 8;

    typedef enum logic {
        UNPK_IDLE,
        UNPK_EMIT
    } unpack_state_t;

endpackage

// File: rtl/wavelet_accelerator_data_unpacker_reg.sv
// Generic enabled register with load and manual clear.
// Holds the word being serialized by the unpacker.
module wavelet_accelerator_data_unpacker_reg #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load_data,
    input  logic             manual_rst,
    input  logic [WIDTH-1:0] rst_value,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out
);

    logic [WIDTH-1:0] data_d;
    logic [WIDTH-1:0] data_q;

    // Next value: clear has priority over load, both gated by enable
    always_comb begin
        data_d = data_q;
        if (en) begin
            if (manual_rst) begin
                data_d = rst_value;
            end else if (load_data) begin
                data_d = data_in;
            end
        end
    end

    // Storage with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign data_out = data_q;

endmodule

// File: rtl/wavelet_accelerator_data_unpacker.sv
// Word-to-byte serializer: emits lanes start..last of each accepted word,
// one packet per handshake, tagged with its lane index.
module wavelet_accelerator_data_unpacker
    import wavelet_accelerator_pkg::*;
#(
    parameter int INPUT_WIDTH  = WA_WORD_WIDTH,
    parameter int PACKET_WIDTH = WA_PACKET_WIDTH,
    localparam int NUM_PACKETS  = INPUT_WIDTH / PACKET_WIDTH,
    localparam int OFFSET_WIDTH = $clog2(NUM_PACKETS)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    word_valid,
    output logic                    word_ready,
    input  logic [INPUT_WIDTH-1:0]  data_in,
    input  logic [OFFSET_WIDTH-1:0] start_offset,
    input  logic [OFFSET_WIDTH-1:0] last_offset,
    output logic                    pkt_valid,
    input  logic                    pkt_ready,
    output logic [PACKET_WIDTH-1:0] data_out,
    output logic [OFFSET_WIDTH-1:0] byte_offset,
    output logic                    pkt_last,
    output logic                    busy
);

    unpack_state_t           state_d;
    unpack_state_t           state_q;
    logic [OFFSET_WIDTH-1:0] cur_d;
    logic [OFFSET_WIDTH-1:0] cur_q;
    logic [OFFSET_WIDTH-1:0] last_d;
    logic [OFFSET_WIDTH-1:0] last_q;
    logic [OFFSET_WIDTH-1:0] last_eff;
    logic [INPUT_WIDTH-1:0]  held_q;
    logic                    emit;
    logic                    lane_last;
    logic                    accept;
    logic                    pkt_fire;

    // A reversed range collapses to the single start lane
    assign last_eff  = (last_offset < start_offset) ? start_offset : last_offset;

    assign emit      = (state_q == UNPK_EMIT);
    assign lane_last = emit && (cur_q == last_q);

    // Ready is combinational from pkt_ready so words chain without a bubble
    assign word_ready = en && !rst && (!emit || (pkt_ready && lane_last));
    assign pkt_valid  = en && !rst && emit;
    assign pkt_last   = !rst && lane_last;
    assign busy       = !rst && emit;
    assign data_out   = rst ? '0 : held_q[int'(cur_q)*PACKET_WIDTH +: PACKET_WIDTH];
    assign byte_offset = rst ? '0 : cur_q;

    assign accept   = word_valid && word_ready;
    assign pkt_fire = pkt_valid && pkt_ready;

    wavelet_accelerator_data_unpacker_reg #(
        .WIDTH(INPUT_WIDTH)
    ) u_word_reg (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .load_data  (accept),
        .manual_rst (1'b0),
        .rst_value  ({INPUT_WIDTH{1'b0}}),
        .data_in    (data_in),
        .data_out   (held_q)
    );

    // Lane advance on handshake; a word accept reloads the lane range
    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        last_d  = last_q;
        if (pkt_fire) begin
            if (lane_last) begin
                state_d = UNPK_IDLE;
            end else begin
                cur_d = cur_q + OFFSET_WIDTH'(1);
            end
        end
        if (accept) begin
            state_d = UNPK_EMIT;
            cur_d   = start_offset;
            last_d  = last_eff;
        end
    end

    // FSM state, lane counter and held end offset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= UNPK_IDLE;
            cur_q   <= '0;
            last_q  <= '0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            last_q  <= last_d;
        end
    end

endmodule
